mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one synchronous single-port data RAM between the CPU memory stage and the
//  VGA pixel fetcher. Issues at most one access per cycle, CPU has priority, and a
//  starvation guard guarantees VGA service. Read data returns one cycle after issue.
//  It replaces the dual-port arrangement so the data RAM fits one BRAM port.
// PARAMETERS
//  ADDR_W        16  word address width (both requesters, RAM)
//  DATA_W        32  data word width
//  MAX_VGA_WAIT   4  cycles VGA may be denied before it is forced to win (>=1)
// PORTS
//  clk         in   1       system clock, all state on rising edge
//  rst         in   1       asynchronous, active-high reset
//  cpu_req     in   1       CPU access request, held until cpu_ack
//  cpu_we      in   1       1=write, 0=read (valid with cpu_req)
//  cpu_addr    in   ADDR_W  CPU word address (ALU result low bits)
//  cpu_wdata   in   DATA_W  CPU write data
//  cpu_ack     out  1       access issued this cycle (combinational)
//  cpu_rvalid  out  1       cpu_rdata valid (registered, 1 cycle after read ack)
//  cpu_rdata   out  DATA_W  CPU read data
//  vga_req     in   1       VGA read request, held until vga_ack
//  vga_addr    in   ADDR_W  VGA word address
//  vga_ack     out  1       VGA read issued this cycle (combinational)
//  vga_rvalid  out  1       vga_rdata valid (registered, 1 cycle after vga_ack)
//  vga_rdata   out  DATA_W  VGA read data
//  ram_addr    out  ADDR_W  RAM address (combinational from winner)
//  ram_wdata   out  DATA_W  RAM write data (= cpu_wdata)
//  ram_we      out  1       RAM write enable, only when CPU write wins
//  ram_q       in   DATA_W  RAM read data, valid cycle after address presented
// BEHAVIOUR
//  - Reset: owner=OWN_NONE, wait_cnt=0, cpu_rvalid=vga_rvalid=0; acks/ram_we follow
//    comb logic and are 0 while rst high. rdata outputs pass ram_q (don't-care unless valid).
//  - Arbitration per cycle: force_vga = vga_req && wait_cnt>=MAX_VGA_WAIT.
//    force_vga -> VGA wins; else cpu_req -> CPU wins; else vga_req -> VGA wins; else idle.
//  - Winner gets ack=1 same cycle; loser ack=0 and must hold request and fields stable.
//  - Idle: ram_addr=0, ram_we=0. VGA win: ram_addr=vga_addr, ram_we=0.
//    CPU win: ram_addr=cpu_addr, ram_we=cpu_we.
//  - Return owner register (states OWN_NONE/OWN_CPU/OWN_VGA), next state each cycle:
//    CPU read ack->OWN_CPU; VGA ack->OWN_VGA; CPU write or idle->OWN_NONE.
//    cpu_rvalid=(owner==OWN_CPU), vga_rvalid=(owner==OWN_VGA); rdata = ram_q.
//  - Latency: read ack in cycle N -> rvalid and data in cycle N+1. Back-to-back reads
//    allowed every cycle; throughput 1 access/cycle. Writes produce no rvalid.
//  - wait_cnt: +1 each cycle vga_req && !vga_ack, saturating at MAX_VGA_WAIT;
//    cleared on vga_ack or when vga_req=0.
//  - Simultaneous req, counter below limit: CPU wins, VGA waits. At limit: VGA wins
//    exactly one cycle, counter clears, CPU (held) wins next cycle.
//  - Worst-case CPU stall = 1 cycle per MAX_VGA_WAIT+1; worst VGA latency = MAX_VGA_WAIT+1.
//  - Reset asserted mid-read: pending return discarded, no rvalid after reset release.
// STRUCTURE
//  - mem_arb_pkg: typedef enum logic[1:0] {OWN_NONE,OWN_CPU,OWN_VGA} owner_t;
//    localparam defaults for ADDR_W/DATA_W shared with memory stage and VGA fetcher.
//  - Sub-module arb_wait_counter (saturating counter, inc/clr, limit flag) instantiated
//    once; grant mux and owner register stay in the top module.
// TESTING
//  1. CPU read only: cpu_req=1,we=0,addr=0x0010, RAM holds 0xDEADBEEF -> cpu_ack same
//     cycle, ram_addr=0x0010, next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF.
//  2. CPU write: we=1,addr=0x0020,wdata=0x12345678 -> ram_we=1 one cycle, no rvalid;
//     subsequent read of 0x0020 returns 0x12345678.
//  3. Contention: cpu_req and vga_req held from cycle 0, MAX_VGA_WAIT=4 -> cpu_ack
//     cycles 0-3, vga_ack cycle 4, cpu_ack cycle 5; vga_rvalid cycle 5, no cycle with both acks.
//  4. Streaming VGA: vga_req held, addr 0x0100..0x0107 advanced on each ack, no CPU ->
//     8 consecutive acks, vga_rvalid cycles 1-8 with matching RAM words.
//  5. Reset mid-read: CPU read acked in cycle N, rst high in N (async) -> cpu_rvalid=0
//     in N+1, wait_cnt=0, owner=OWN_NONE after release.
//  6. Alternating read owners back-to-back (CPU read, VGA read, CPU read) -> rvalid
//     tags alternate exactly, each rdata matches its own address.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and default widths for the data-RAM port
//               arbiter, the CPU memory stage and the VGA pixel fetcher.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int c_addr_w_default       = 16;
    localparam int c_data_w_default       = 32;
    localparam int c_max_vga_wait_default = 4;

    // Who owns the read data returning from the RAM in the current cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VGA  = 2'd2
    } owner_t;

    // Writes and idle cycles return nothing, so they map to OWN_NONE.
    function automatic owner_t next_owner(input logic cpu_read_issued,
                                          input logic vga_read_issued);
        owner_t own;
        own = OWN_NONE;
        if (cpu_read_issued) begin
            own = OWN_CPU;
        end else if (vga_read_issued) begin
            own = OWN_VGA;
        end
        return own;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_wait_counter.sv
`default_nettype none
// ============================================================================
// Module      : arb_wait_counter
// Description : Saturating counter of consecutive cycles a requester has been
//               denied. Clear has priority over increment.
// Ports       : clk, rst (async, active-high)
//               i_inc       count one denied cycle
//               i_clr       restart from zero
//               o_at_limit  count has reached LIMIT
// Revision    : 1.0 - initial release
// ============================================================================
module arb_wait_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_limit
);

    localparam int                   c_cnt_w = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [c_cnt_w-1:0]   c_limit = c_cnt_w'(LIMIT);
    localparam logic [c_cnt_w-1:0]   c_one   = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_limit)) begin
            r_count <= r_count + c_one;
        end
    end

    assign o_at_limit = (r_count >= c_limit);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one synchronous single-port data RAM between the CPU
//               memory stage and the VGA pixel fetcher. One access per cycle,
//               CPU has priority, a starvation guard forces a VGA grant after
//               MAX_VGA_WAIT denied cycles. Read data returns one cycle after
//               the access is issued.
// Ports       : clk, rst (async, active-high)
//               cpu_req/we/addr/wdata -> cpu_ack, cpu_rvalid, cpu_rdata
//               vga_req/addr          -> vga_ack, vga_rvalid, vga_rdata
//               ram_addr/wdata/we     -> RAM, ram_q <- RAM read data
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = c_addr_w_default,
    parameter int DATA_W       = c_data_w_default,
    parameter int MAX_VGA_WAIT = c_max_vga_wait_default
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_ack,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    logic   w_at_limit;
    logic   w_force_vga;
    logic   w_cpu_win;
    logic   w_vga_win;
    owner_t w_next_owner;
    owner_t r_owner;

    // Grants are suppressed while reset is held so nothing reaches the RAM.
    assign w_force_vga = vga_req && w_at_limit;
    assign w_cpu_win   = !rst && cpu_req && !w_force_vga;
    assign w_vga_win   = !rst && vga_req && !w_cpu_win;

    assign cpu_ack   = w_cpu_win;
    assign vga_ack   = w_vga_win;
    assign ram_we    = w_cpu_win && cpu_we;
    assign ram_wdata = cpu_wdata;

    always_comb begin
        ram_addr = '0;
        if (w_cpu_win) begin
            ram_addr = cpu_addr;
        end else if (w_vga_win) begin
            ram_addr = vga_addr;
        end
    end

    // Counts VGA's denied cycles; a dropped request also restarts the count.
    arb_wait_counter #(
        .LIMIT (MAX_VGA_WAIT)
    ) u_wait_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_inc      (vga_req && !w_vga_win),
        .i_clr      (w_vga_win || !vga_req),
        .o_at_limit (w_at_limit)
    );

    // Remembers whose read is in flight so the returning ram_q is tagged.
    assign w_next_owner = next_owner(w_cpu_win && !cpu_we, w_vga_win);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= OWN_NONE;
        end else begin
            r_owner <= w_next_owner;
        end
    end

    assign cpu_rvalid = (r_owner == OWN_CPU);
    assign vga_rvalid = (r_owner == OWN_VGA);
    assign cpu_rdata  = ram_q;
    assign vga_rdata  = ram_q;

endmodule
`default_nettype wire
